// File: rtl/unidade_funcional.sv
// -----------------------------------------------------------------------------
// unidade_funcional
// Adder-class functional unit of the Tomasulo core. It takes one issued
// instruction from the adder reservation station and reads both source
// operands from R1..R7. The result is computed over a fixed latency. When the
// operation finishes, done pulses for one cycle together with the result, the
// instruction word and the RS-line tag.
//
// Parameters
//   WIDTH    data / instruction width (instruction fields assume 16 bits)
//   LATENCY  cycles from the accept edge to the done edge, 1..15
//
// Ports
//   Clock        system clock, rising edge
//   Reset        asynchronous, active-high reset
//   R1..R7       architectural register values (R0 reads as zero)
//   instruction  issued instruction: [3:0] opcode, [6:4] Rx, [9:7] Ry,
//                [12:10] Rz, [15:10] imm6 for ld/sd
//   enable       issue strobe for instruction/tagIn
//   tagIn        RS line of the issued instruction
//   tagOut       RS line of the completed instruction
//   done         one-cycle completion pulse
//   doneInst     completed instruction word
//   dout         result
//   disponivel   unit idle, an issue is accepted this cycle
//   ovf          signed overflow of add/sub (only with UF_OVERFLOW_EN)
//
// Optional feature macro: UF_OVERFLOW_EN adds the ovf output.
// -----------------------------------------------------------------------------
module unidade_funcional #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] R1,
    input  logic [WIDTH-1:0] R2,
    input  logic [WIDTH-1:0] R3,
    input  logic [WIDTH-1:0] R4,
    input  logic [WIDTH-1:0] R5,
    input  logic [WIDTH-1:0] R6,
    input  logic [WIDTH-1:0] R7,
    input  logic [WIDTH-1:0] instruction,
    input  logic             enable,
    input  logic [2:0]       tagIn,
    output logic [2:0]       tagOut,
    output logic             done,
    output logic [WIDTH-1:0] doneInst,
    output logic [WIDTH-1:0] dout,
    output logic             disponivel
`ifdef UF_OVERFLOW_EN
   ,output logic             ovf
`endif
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0100;

    // Result of the latched operation. An unknown opcode is treated as
    // ld/sd address generation: the base is Ry and the offset is imm6,
    // sign-extended to the full width.
    function automatic logic [WIDTH-1:0] alu_result(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [5:0]       imm
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_ADD:  r = y + x;
            OP_SUB:  r = y - x;
            OP_AND:  r = y & x;
            default: r = y + {{(WIDTH-6){imm[5]}}, imm};
        endcase
        return r;
    endfunction

`ifdef UF_OVERFLOW_EN
    // Signed two's-complement overflow. For a sum, the operands have the
    // same sign but the result sign differs. For a difference (y - x), the
    // operands have different signs and the result sign differs from y.
    function automatic logic alu_ovf(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] r
    );
        logic v;
        case (op)
            OP_ADD:  v = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != y[WIDTH-1]);
            OP_SUB:  v = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != y[WIDTH-1]);
            default: v = 1'b0;
        endcase
        return v;
    endfunction
`endif

    logic [WIDTH-1:0] op_x_s;
    logic [WIDTH-1:0] op_y_s;
    logic [WIDTH-1:0] result_s;

    logic             busy_r;
    logic [3:0]       count_r;
    logic [WIDTH-1:0] inst_r;
    logic [2:0]       tag_r;
    logic [WIDTH-1:0] opx_r;
    logic [WIDTH-1:0] opy_r;
    logic             done_r;
    logic [WIDTH-1:0] dout_r;
    logic [WIDTH-1:0] done_inst_r;
    logic [2:0]       tag_out_r;
`ifdef UF_OVERFLOW_EN
    logic             ovf_r;
`endif

    // Rx operand mux (select 0 is the hard-wired zero register).
    always_comb begin
        op_x_s = '0;
        case (instruction[6:4])
            3'd1:    op_x_s = R1;
            3'd2:    op_x_s = R2;
            3'd3:    op_x_s = R3;
            3'd4:    op_x_s = R4;
            3'd5:    op_x_s = R5;
            3'd6:    op_x_s = R6;
            3'd7:    op_x_s = R7;
            default: op_x_s = '0;
        endcase
    end

    // Ry operand mux (select 0 is the hard-wired zero register).
    always_comb begin
        op_y_s = '0;
        case (instruction[9:7])
            3'd1:    op_y_s = R1;
            3'd2:    op_y_s = R2;
            3'd3:    op_y_s = R3;
            3'd4:    op_y_s = R4;
            3'd5:    op_y_s = R5;
            3'd6:    op_y_s = R6;
            3'd7:    op_y_s = R7;
            default: op_y_s = '0;
        endcase
    end

    // Result of the in-flight operation, computed from the captured operands.
    always_comb begin
        result_s = alu_result(inst_r[3:0], opx_r, opy_r, inst_r[15:10]);
    end

    // Issue, countdown and completion. The unit accepts a new issue only when
    // idle, so an enable while busy is simply dropped.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            busy_r      <= 1'b0;
            count_r     <= 4'd0;
            inst_r      <= '0;
            tag_r       <= 3'd0;
            opx_r       <= '0;
            opy_r       <= '0;
            done_r      <= 1'b0;
            dout_r      <= '0;
            done_inst_r <= '0;
            tag_out_r   <= 3'd0;
`ifdef UF_OVERFLOW_EN
            ovf_r       <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            if (!busy_r) begin
                if (enable) begin
                    busy_r  <= 1'b1;
                    count_r <= 4'(LATENCY);
                    inst_r  <= instruction;
                    tag_r   <= tagIn;
                    opx_r   <= op_x_s;
                    opy_r   <= op_y_s;
                end else begin
                    count_r <= 4'd0;
                end
            end else if (count_r == 4'd1) begin
                // The count expires on this edge: publish the result and free
                // the unit, so that the next issue is taken at the following edge.
                busy_r      <= 1'b0;
                count_r     <= 4'd0;
                done_r      <= 1'b1;
                dout_r      <= result_s;
                done_inst_r <= inst_r;
                tag_out_r   <= tag_r;
`ifdef UF_OVERFLOW_EN
                ovf_r       <= alu_ovf(inst_r[3:0], opx_r, opy_r, result_s);
`endif
            end else begin
                count_r <= count_r - 4'd1;
            end
        end
    end

    assign disponivel = ~busy_r;
    assign done       = done_r;
    assign dout       = dout_r;
    assign doneInst   = done_inst_r;
    assign tagOut     = tag_out_r;
`ifdef UF_OVERFLOW_EN
    assign ovf        = ovf_r;
`endif

endmodule

// File: tb/tb_unidade_funcional.sv
// -----------------------------------------------------------------------------
// tb_unidade_funcional
// Directed-vector bench for unidade_funcional with LATENCY=2. The expected
// values are hand-computed constants. Every comparison goes through check_eq.
// -----------------------------------------------------------------------------
module tb_unidade_funcional;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] R1, R2, R3, R4, R5, R6, R7;
    logic [15:0] instruction;
    logic        enable;
    logic [2:0]  tagIn;
    logic [2:0]  tagOut;
    logic        done;
    logic [15:0] doneInst;
    logic [15:0] dout;
    logic        disponivel;
`ifdef UF_OVERFLOW_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    unidade_funcional #(.WIDTH(16), .LATENCY(2)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .R1          (R1),
        .R2          (R2),
        .R3          (R3),
        .R4          (R4),
        .R5          (R5),
        .R6          (R6),
        .R7          (R7),
        .instruction (instruction),
        .enable      (enable),
        .tagIn       (tagIn),
        .tagOut      (tagOut),
        .done        (done),
        .doneInst    (doneInst),
        .dout        (dout),
        .disponivel  (disponivel)
`ifdef UF_OVERFLOW_EN
       ,.ovf         (ovf)
`endif
    );

    // Free-running clock, 10 time units per period.
    always #5 Clock = ~Clock;

    // Global time limit so that a stuck run still terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "time limit");
    end

    task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rx,
                                       input logic [2:0] ry, input logic [2:0] rz);
        return {3'b000, rz, ry, rx, op};
    endfunction

    // Drive one issue across one rising edge. Returns at the falling edge
    // after the accept edge.
    task automatic issue(input logic [15:0] inst, input logic [2:0] tag);
        @(negedge Clock);
        instruction = inst;
        tagIn       = tag;
        enable      = 1'b1;
        @(negedge Clock);
        enable      = 1'b0;
    endtask

    // Count falling edges until done is seen, with a bounded wait.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 10) begin
            @(negedge Clock);
            cycles++;
        end
    endtask

    task automatic run_op(input string name, input logic [15:0] inst,
                          input logic [2:0] tag, input logic [15:0] exp);
        int c;
        issue(inst, tag);
        check_eq({name, "_busy"}, 32'(disponivel), 32'd0);
        wait_done(c);
        check_eq({name, "_latency"}, 32'(c), 32'd2);
        check_eq({name, "_dout"}, 32'(dout), 32'(exp));
        check_eq({name, "_tag"}, 32'(tagOut), 32'(tag));
        check_eq({name, "_inst"}, 32'(doneInst), 32'(inst));
        check_eq({name, "_idle"}, 32'(disponivel), 32'd1);
        @(negedge Clock);
        check_eq({name, "_pulse"}, 32'(done), 32'd0);
        check_eq({name, "_hold"}, 32'(dout), 32'(exp));
    endtask

    initial begin
        int pulses;
        Reset       = 1'b1;
        enable      = 1'b0;
        instruction = 16'h0000;
        tagIn       = 3'd0;
        R1 = 16'd100;  R2 = 16'd5;     R3 = 16'd7;
        R4 = 16'hF0F0; R5 = 16'h3C3C;  R6 = 16'h7FFF; R7 = 16'h0001;

        repeat (2) @(negedge Clock);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_dout", 32'(dout), 32'd0);
        check_eq("rst_tag", 32'(tagOut), 32'd0);
        check_eq("rst_inst", 32'(doneInst), 32'd0);
        check_eq("rst_idle", 32'(disponivel), 32'd1);
`ifdef UF_OVERFLOW_EN
        check_eq("rst_ovf", 32'(ovf), 32'd0);
`endif
        Reset = 1'b0;

        // R3 + R2 = 12
        run_op("add", mk(4'b0000, 3'd3, 3'd2, 3'd1), 3'd4, 16'd12);
`ifdef UF_OVERFLOW_EN
        check_eq("add_ovf", 32'(ovf), 32'd0);
`endif
        // R3 - R0 = 7
        run_op("sub_r0", mk(4'b0001, 3'd0, 3'd3, 3'd0), 3'd2, 16'd7);
        // R2 - R3 = 5 - 7
        run_op("sub_neg", mk(4'b0001, 3'd3, 3'd2, 3'd0), 3'd7, 16'hFFFE);
        // R4 & R5
        run_op("and", mk(4'b0100, 3'd5, 3'd4, 3'd0), 3'd1, 16'h3030);
        // ld: R1 + sext(111110) = 100 - 2
        run_op("ld", {6'b111110, 3'b001, 3'b000, 4'b0010}, 3'd6, 16'd98);
        // R6 + R7 = 7FFF + 1
        run_op("add_wrap", mk(4'b0000, 3'd7, 3'd6, 3'd0), 3'd3, 16'h8000);
`ifdef UF_OVERFLOW_EN
        check_eq("add_wrap_ovf", 32'(ovf), 32'd1);
`endif

        // An enable while busy is ignored, and changing R2 after the accept
        // edge does not affect the captured operand.
        issue(mk(4'b0000, 3'd3, 3'd2, 3'd0), 3'd1);
        instruction = mk(4'b0001, 3'd0, 3'd3, 3'd0);
        tagIn       = 3'd2;
        enable      = 1'b1;
        R2          = 16'd100;
        @(negedge Clock);
        enable = 1'b0;
        check_eq("ign_early", 32'(done), 32'd0);
        @(negedge Clock);
        check_eq("ign_done", 32'(done), 32'd1);
        check_eq("ign_tag", 32'(tagOut), 32'd1);
        check_eq("ign_dout", 32'(dout), 32'd12);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            if (done === 1'b1) pulses++;
        end
        check_eq("ign_extra", 32'(pulses), 32'd0);
        check_eq("ign_idle", 32'(disponivel), 32'd1);
        R2 = 16'd5;

        // Back-to-back issue with enable held high. The second op is accepted
        // at the edge that ends the first done cycle.
        @(negedge Clock);
        instruction = mk(4'b0000, 3'd3, 3'd2, 3'd0);
        tagIn       = 3'd3;
        enable      = 1'b1;
        @(negedge Clock);
        instruction = mk(4'b0001, 3'd0, 3'd3, 3'd0);
        tagIn       = 3'd5;
        check_eq("b2b_busy1", 32'(disponivel), 32'd0);
        @(negedge Clock);
        check_eq("b2b_wait1", 32'(done), 32'd0);
        @(negedge Clock);
        check_eq("b2b_done1", 32'(done), 32'd1);
        check_eq("b2b_tag1", 32'(tagOut), 32'd3);
        check_eq("b2b_dout1", 32'(dout), 32'd12);
        check_eq("b2b_idle", 32'(disponivel), 32'd1);
        @(negedge Clock);
        enable = 1'b0;
        check_eq("b2b_fall", 32'(done), 32'd0);
        check_eq("b2b_busy2", 32'(disponivel), 32'd0);
        @(negedge Clock);
        check_eq("b2b_wait2", 32'(done), 32'd0);
        @(negedge Clock);
        check_eq("b2b_done2", 32'(done), 32'd1);
        check_eq("b2b_tag2", 32'(tagOut), 32'd5);
        check_eq("b2b_dout2", 32'(dout), 32'd7);

        // Reset one cycle after accept: outputs clear at once and the
        // in-flight op never completes.
        issue(mk(4'b0000, 3'd3, 3'd2, 3'd0), 3'd6);
        Reset = 1'b1;
        #1;
        check_eq("mid_dout", 32'(dout), 32'd0);
        check_eq("mid_tag", 32'(tagOut), 32'd0);
        check_eq("mid_inst", 32'(doneInst), 32'd0);
        check_eq("mid_done", 32'(done), 32'd0);
        check_eq("mid_idle", 32'(disponivel), 32'd1);
        @(negedge Clock);
        Reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            if (done === 1'b1) pulses++;
        end
        check_eq("mid_nodone", 32'(pulses), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
